// File: rtl/flit_ejector.sv
// Network ejection port: per-VC flit FIFOs drained to the local sink by round-robin,
// with one credit returned upstream for every flit the sink consumes.
module flit_ejector #(
  parameter int FLIT_WIDTH    = 36,
  parameter int A_WIDTH       = 8,
  parameter int NVCS          = 2,
  parameter int DEPTH         = 4,
  parameter int VC_LSB        = 0,
  parameter int MY_ADDR       = 0,
  parameter int UPSTREAM_ADDR = 1,
  localparam int LOG_NVCS     = (NVCS > 1) ? $clog2(NVCS) : 1,
  localparam int CREDIT_WIDTH = LOG_NVCS + 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [FLIT_WIDTH-1:0]   flit_in,
  input  logic                    flit_in_valid,
  input  logic [A_WIDTH-1:0]      nexthop_in,
  output logic                    dequeue,
  output logic [FLIT_WIDTH-1:0]   sink_flit,
  output logic [LOG_NVCS-1:0]     sink_vc,
  output logic                    sink_valid,
  input  logic                    sink_ready,
  output logic [CREDIT_WIDTH-1:0] credit_out,
  output logic                    credit_out_valid,
  output logic [A_WIDTH-1:0]      credit_out_nexthop,
  input  logic                    credit_dequeue,
  output logic                    is_quiescent,
  output logic                    error
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PTR_W = AW + 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_EXT = DEPTH;

  logic [FLIT_WIDTH-1:0] r_mem [NVCS][DEPTH];
  logic [PTR_W-1:0]      r_wptr [NVCS];
  logic [PTR_W-1:0]      r_rptr [NVCS];
  logic [CNT_W-1:0]      r_pend [NVCS];
  logic [LOG_NVCS-1:0]   r_sink_ptr, r_sink_lock_vc, r_cred_ptr, r_cred_lock_vc;
  logic                  r_sink_lock, r_cred_lock, r_error;

  logic [NVCS-1:0]       w_full, w_nonempty, w_pend_nz, w_inc, w_dec, w_ovf;
  logic [CNT_W-1:0]      w_pend_nxt [NVCS];
  logic [LOG_NVCS-1:0]   w_vc_in, w_sink_sel, w_cred_sel;
  logic [AW-1:0]         w_rd_idx;
  logic                  w_vc_ok, w_deq, w_sink_valid, w_pop, w_cred_valid, w_cred_take;

  function automatic logic [LOG_NVCS-1:0] rr_pick(input logic [NVCS-1:0] req,
                                                  input logic [LOG_NVCS-1:0] start);
    logic [LOG_NVCS-1:0] pick;
    logic                found;
    int                  idx;
    pick  = start;
    found = 1'b0;
    for (int i = 0; i < NVCS; i++) begin
      idx = (int'(start) + i) % NVCS;
      if (!found && req[idx]) begin
        pick  = LOG_NVCS'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [LOG_NVCS-1:0] vc_inc(input logic [LOG_NVCS-1:0] vc);
    return LOG_NVCS'((int'(vc) + 1) % NVCS);
  endfunction

  // Returns {overflow, saturated count}; the count never exceeds DEPTH.
  function automatic logic [CNT_W:0] pend_update(input logic [CNT_W-1:0] cur,
                                                 input logic inc, input logic dec);
    logic [CNT_W:0] sum;
    sum = {1'b0, cur} + {{CNT_W{1'b0}}, inc} - {{CNT_W{1'b0}}, dec};
    if (sum > DEPTH_EXT) return {1'b1, DEPTH_EXT[CNT_W-1:0]};
    return {1'b0, sum[CNT_W-1:0]};
  endfunction

  always_comb begin
    for (int v = 0; v < NVCS; v++) begin
      w_full[v]     = (r_wptr[v] - r_rptr[v]) == PTR_W'(DEPTH);
      w_nonempty[v] = r_wptr[v] != r_rptr[v];
      w_pend_nz[v]  = r_pend[v] != '0;
    end
  end

  assign w_vc_in      = flit_in[VC_LSB +: LOG_NVCS];
  assign w_vc_ok      = int'(w_vc_in) < NVCS;
  assign w_deq        = ~reset & enable & flit_in_valid & w_vc_ok & ~w_full[w_vc_in];

  // The lock keeps a shown-but-unaccepted choice stable against newly filled VCs.
  assign w_sink_sel   = r_sink_lock ? r_sink_lock_vc : rr_pick(w_nonempty, r_sink_ptr);
  assign w_sink_valid = ~reset & enable & w_nonempty[w_sink_sel];
  assign w_pop        = w_sink_valid & sink_ready;
  assign w_rd_idx     = r_rptr[w_sink_sel][AW-1:0];

  assign w_cred_sel   = r_cred_lock ? r_cred_lock_vc : rr_pick(w_pend_nz, r_cred_ptr);
  assign w_cred_valid = ~reset & enable & (|w_pend_nz);
  assign w_cred_take  = w_cred_valid & credit_dequeue;

  always_comb begin
    for (int v = 0; v < NVCS; v++) begin
      w_inc[v] = w_pop && (w_sink_sel == LOG_NVCS'(v));
      w_dec[v] = w_cred_take && (w_cred_sel == LOG_NVCS'(v));
      {w_ovf[v], w_pend_nxt[v]} = pend_update(r_pend[v], w_inc[v], w_dec[v]);
    end
  end

  assign dequeue            = w_deq;
  assign sink_valid         = w_sink_valid;
  assign sink_flit          = w_sink_valid ? r_mem[w_sink_sel][w_rd_idx] : '0;
  assign sink_vc            = w_sink_valid ? w_sink_sel : '0;
  assign credit_out_valid   = w_cred_valid;
  assign credit_out         = w_cred_valid ? {1'b1, w_cred_sel} : '0;
  assign credit_out_nexthop = A_WIDTH'(UPSTREAM_ADDR);
  assign is_quiescent       = reset | (~(|w_nonempty) & ~(|w_pend_nz));
  assign error              = r_error & ~reset;

  // Stage p0: flit storage, written on the accepting edge, not reset
  always_ff @(posedge clock) begin
    if (w_deq) r_mem[w_vc_in][r_wptr[w_vc_in][AW-1:0]] <= flit_in;
  end

  // Stage p0: FIFO pointers, arbitration state, credit counters, error flag
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int v = 0; v < NVCS; v++) begin
        r_wptr[v] <= '0;
        r_rptr[v] <= '0;
        r_pend[v] <= '0;
      end
      r_sink_ptr     <= '0;
      r_sink_lock    <= 1'b0;
      r_sink_lock_vc <= '0;
      r_cred_ptr     <= '0;
      r_cred_lock    <= 1'b0;
      r_cred_lock_vc <= '0;
      r_error        <= 1'b0;
    end else if (enable) begin
      if (w_deq) begin
        r_wptr[w_vc_in] <= r_wptr[w_vc_in] + PTR_W'(1);
        if (nexthop_in != A_WIDTH'(MY_ADDR)) r_error <= 1'b1;
      end
      if (w_pop) begin
        r_rptr[w_sink_sel] <= r_rptr[w_sink_sel] + PTR_W'(1);
        r_sink_ptr         <= vc_inc(w_sink_sel);
        r_sink_lock        <= 1'b0;
      end else if (w_sink_valid) begin
        r_sink_lock    <= 1'b1;
        r_sink_lock_vc <= w_sink_sel;
      end
      if (w_cred_take) begin
        r_cred_ptr  <= vc_inc(w_cred_sel);
        r_cred_lock <= 1'b0;
      end else if (w_cred_valid) begin
        r_cred_lock    <= 1'b1;
        r_cred_lock_vc <= w_cred_sel;
      end
      for (int v = 0; v < NVCS; v++) r_pend[v] <= w_pend_nxt[v];
      if (|w_ovf) r_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_flit_ejector.sv
// Bench for flit_ejector: directed scenarios plus randomized traffic against a
// queue-based reference model of the ejector.
module tb_flit_ejector;
  localparam int FW = 36, AW = 8, N = 2, D = 4, MY = 0, UP = 1;

  logic          clock = 1'b0;
  logic          reset, enable, flit_in_valid, sink_ready, credit_dequeue;
  logic [FW-1:0] flit_in;
  logic [AW-1:0] nexthop_in;
  logic          dequeue, sink_valid, credit_out_valid, is_quiescent, error;
  logic [FW-1:0] sink_flit;
  logic [0:0]    sink_vc;
  logic [1:0]    credit_out;
  logic [AW-1:0] credit_out_nexthop;

  always #5 clock = ~clock;

  flit_ejector #(.FLIT_WIDTH(FW), .A_WIDTH(AW), .NVCS(N), .DEPTH(D), .VC_LSB(0),
                 .MY_ADDR(MY), .UPSTREAM_ADDR(UP)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .flit_in(flit_in), .flit_in_valid(flit_in_valid), .nexthop_in(nexthop_in),
    .dequeue(dequeue), .sink_flit(sink_flit), .sink_vc(sink_vc),
    .sink_valid(sink_valid), .sink_ready(sink_ready),
    .credit_out(credit_out), .credit_out_valid(credit_out_valid),
    .credit_out_nexthop(credit_out_nexthop), .credit_dequeue(credit_dequeue),
    .is_quiescent(is_quiescent), .error(error));

  int checks = 0;
  int errors = 0;

  // Reference model state: queues of stored flits, popped-but-uncredited counts
  logic [FW-1:0] mq [N][$];
  int  m_pend [N] = '{0, 0};
  int  m_sptr = 0, m_cptr = 0, m_shold = -1, m_chold = -1;
  bit  m_err = 0;

  int            e_sel, e_csel;
  bit            e_deq, e_sv, e_cv, e_quiet, e_err;
  logic [FW-1:0] e_flit;
  logic [0:0]    e_svc;
  logic [1:0]    e_credit;

  task automatic model_eval();
    bit found;
    int k;
    int vc;
    vc = int'(flit_in[0]);
    e_deq = !reset && enable && flit_in_valid && (mq[vc].size() < D);
    e_sv = 0; e_sel = 0;
    if (!reset && enable) begin
      if (m_shold >= 0) begin e_sv = 1; e_sel = m_shold; end
      else begin
        found = 0;
        for (int i = 0; i < N; i++) begin
          k = (m_sptr + i) % N;
          if (!found && mq[k].size() > 0) begin found = 1; e_sel = k; end
        end
        e_sv = found;
      end
    end
    e_flit = e_sv ? mq[e_sel][0] : '0;
    e_svc  = e_sv ? 1'(e_sel) : 1'b0;
    e_cv = 0; e_csel = 0;
    if (!reset && enable) begin
      if (m_chold >= 0) begin e_cv = 1; e_csel = m_chold; end
      else begin
        found = 0;
        for (int i = 0; i < N; i++) begin
          k = (m_cptr + i) % N;
          if (!found && m_pend[k] > 0) begin found = 1; e_csel = k; end
        end
        e_cv = found;
      end
    end
    e_credit = e_cv ? {1'b1, 1'(e_csel)} : 2'b00;
    e_quiet = 1;
    for (int v = 0; v < N; v++) if (mq[v].size() > 0 || m_pend[v] > 0) e_quiet = 0;
    if (reset) e_quiet = 1;
    e_err = !reset && m_err;
  endtask

  task automatic model_commit();
    int inc [N];
    int dec [N];
    int np;
    if (reset) begin
      for (int v = 0; v < N; v++) begin mq[v].delete(); m_pend[v] = 0; end
      m_sptr = 0; m_cptr = 0; m_shold = -1; m_chold = -1; m_err = 0;
    end else if (enable) begin
      for (int v = 0; v < N; v++) begin inc[v] = 0; dec[v] = 0; end
      if (e_sv) begin
        if (sink_ready) begin
          void'(mq[e_sel].pop_front());
          inc[e_sel] = 1; m_sptr = (e_sel + 1) % N; m_shold = -1;
        end else m_shold = e_sel;
      end
      if (e_cv) begin
        if (credit_dequeue) begin
          dec[e_csel] = 1; m_cptr = (e_csel + 1) % N; m_chold = -1;
        end else m_chold = e_csel;
      end
      for (int v = 0; v < N; v++) begin
        np = m_pend[v] + inc[v] - dec[v];
        if (np > D) begin m_err = 1; np = D; end
        m_pend[v] = np;
      end
      if (e_deq) begin
        mq[int'(flit_in[0])].push_back(flit_in);
        if (nexthop_in != AW'(MY)) m_err = 1;
      end
    end
  endtask

  task automatic sample();
    @(negedge clock);
    model_eval();
  endtask

  task automatic advance();
    @(posedge clock);
    model_commit();
    #1;
  endtask

  task automatic idle_inputs();
    enable = 1; flit_in_valid = 0; flit_in = '0; nexthop_in = AW'(MY);
    sink_ready = 0; credit_dequeue = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    sample();
    advance();
    reset = 0;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    flit_in_valid = 0; enable = 1; sink_ready = 1; credit_dequeue = 1;
    for (int c = 0; c < 60 && !done; c++) begin
      sample();
      done = is_quiescent;
      advance();
    end
    checks++;
    if (!done) begin errors++; $display("FAIL drain_timeout quiescent=%b required 1", is_quiescent); end
    sink_ready = 0; credit_dequeue = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; flit_in_valid = 1; flit_in = 36'h5_A5A5_A5A5; sink_ready = 1; credit_dequeue = 1;
    sample();
    checks++;
    if ({dequeue, sink_valid, credit_out_valid, is_quiescent, error} !== 5'b00010) begin
      errors++;
      $display("FAIL reset_ctrl deq/sv/cv/quiet/err=%b required 00010",
               {dequeue, sink_valid, credit_out_valid, is_quiescent, error});
    end
    checks++;
    if (sink_flit !== '0 || sink_vc !== 1'b0 || credit_out !== 2'b00) begin
      errors++;
      $display("FAIL reset_data flit=%h vc=%b credit=%b required zeros", sink_flit, sink_vc, credit_out);
    end
    checks++;
    if (credit_out_nexthop !== AW'(UP)) begin
      errors++; $display("FAIL credit_nexthop got %h required %h", credit_out_nexthop, AW'(UP));
    end
    advance();
    idle_inputs();
    reset = 0;
  endtask

  task automatic test_single_flit();
    logic [FW-1:0] f;
    f = 36'h1_2345_6789;
    flit_in = f; flit_in_valid = 1; sink_ready = 1;
    sample();
    checks++;
    if (dequeue !== 1'b1) begin errors++; $display("FAIL single_deq got %b required 1", dequeue); end
    advance();
    flit_in_valid = 0;
    sample();
    checks++;
    if (sink_valid !== 1'b1 || sink_vc !== 1'b1 || sink_flit !== f) begin
      errors++;
      $display("FAIL single_sink valid=%b vc=%b flit=%h required 1 1 %h", sink_valid, sink_vc, sink_flit, f);
    end
    advance();
    credit_dequeue = 1;
    sample();
    checks++;
    if (credit_out_valid !== 1'b1 || credit_out !== 2'b11) begin
      errors++; $display("FAIL single_credit valid=%b credit=%b required 1 11", credit_out_valid, credit_out);
    end
    advance();
    credit_dequeue = 0;
    sample();
    checks++;
    if (is_quiescent !== 1'b1) begin errors++; $display("FAIL single_quiet got %b required 1", is_quiescent); end
    advance();
    idle_inputs();
  endtask

  task automatic test_fifo_full();
    logic [FW-1:0] f [5];
    for (int i = 0; i < 5; i++) f[i] = 36'hA_0000_0000 + FW'(i * 16);
    flit_in_valid = 1; sink_ready = 0;
    for (int i = 0; i < 5; i++) begin
      flit_in = f[i];
      sample();
      checks++;
      if (dequeue !== (i < 4)) begin errors++; $display("FAIL full_deq%0d got %b required %b", i, dequeue, i < 4); end
      advance();
    end
    sink_ready = 1;
    sample();
    checks++;
    if (dequeue !== 1'b0 || sink_flit !== f[0]) begin
      errors++; $display("FAIL full_pop deq=%b flit=%h required 0 %h", dequeue, sink_flit, f[0]);
    end
    advance();
    sink_ready = 0;
    sample();
    checks++;
    if (dequeue !== 1'b1) begin errors++; $display("FAIL full_after_pop got %b required 1", dequeue); end
    advance();
    drain();
    idle_inputs();
  endtask

  task automatic test_alternate();
    int n;
    do_reset();
    flit_in_valid = 1; sink_ready = 0;
    for (int i = 0; i < 8; i++) begin
      flit_in = 36'hB_0000_0000 + FW'(i * 16) + FW'(i % 2);
      sample();
      checks++;
      if (dequeue !== 1'b1) begin errors++; $display("FAIL alt_fill%0d got %b required 1", i, dequeue); end
      advance();
    end
    flit_in_valid = 0; sink_ready = 1;
    for (int k = 0; k < 8; k++) begin
      sample();
      checks++;
      if (sink_valid !== 1'b1 || sink_vc !== 1'(k % 2)) begin
        errors++; $display("FAIL alt_vc%0d valid=%b vc=%b required 1 %0d", k, sink_valid, sink_vc, k % 2);
      end
      advance();
    end
    sink_ready = 0;
    sample();
    checks++;
    if (error !== 1'b0 || credit_out_valid !== 1'b1) begin
      errors++; $display("FAIL alt_pending err=%b cv=%b required 0 1", error, credit_out_valid);
    end
    advance();
    credit_dequeue = 1;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      sample();
      if (credit_out_valid) begin
        checks++;
        if (credit_out !== {1'b1, 1'(n % 2)}) begin
          errors++; $display("FAIL alt_credit%0d got %b required %b", n, credit_out, {1'b1, 1'(n % 2)});
        end
        n++;
      end
      advance();
    end
    checks++;
    if (n != 8) begin errors++; $display("FAIL alt_credit_count got %0d required 8", n); end
    idle_inputs();
  endtask

  task automatic test_bad_addr();
    flit_in = 36'hC_0000_0010; flit_in_valid = 1; nexthop_in = AW'(MY + 1);
    sample();
    checks++;
    if (dequeue !== 1'b1 || error !== 1'b0) begin
      errors++; $display("FAIL badaddr_accept deq=%b err=%b required 1 0", dequeue, error);
    end
    advance();
    idle_inputs();
    sample();
    checks++;
    if (error !== 1'b1) begin errors++; $display("FAIL badaddr_err got %b required 1", error); end
    advance();
    drain();
    sample();
    checks++;
    if (error !== 1'b1) begin errors++; $display("FAIL badaddr_sticky got %b required 1", error); end
    advance();
    do_reset();
    sample();
    checks++;
    if (error !== 1'b0) begin errors++; $display("FAIL badaddr_clear got %b required 0", error); end
    advance();
  endtask

  task automatic test_enable_freeze();
    logic [FW-1:0] fa, fb, fc;
    fa = 36'hD_0000_0010; fb = 36'hD_0000_0021; fc = 36'hD_0000_0030;
    do_reset();
    flit_in_valid = 1; sink_ready = 0;
    flit_in = fa; sample(); advance();
    flit_in = fb; sample(); advance();
    flit_in = fc; sample(); advance();
    flit_in_valid = 0; sink_ready = 1;
    sample(); advance();
    sink_ready = 0;
    sample();
    checks++;
    if (sink_vc !== 1'b1 || sink_flit !== fb || credit_out !== 2'b10) begin
      errors++; $display("FAIL freeze_before vc=%b flit=%h credit=%b required 1 %h 10", sink_vc, sink_flit, credit_out, fb);
    end
    advance();
    enable = 0; flit_in_valid = 1; flit_in = 36'hD_0000_0041; sink_ready = 1; credit_dequeue = 1;
    for (int k = 0; k < 3; k++) begin
      sample();
      checks++;
      if ({dequeue, sink_valid, credit_out_valid} !== 3'b000) begin
        errors++; $display("FAIL freeze_cyc%0d deq/sv/cv=%b required 000", k, {dequeue, sink_valid, credit_out_valid});
      end
      advance();
    end
    enable = 1; flit_in_valid = 0; sink_ready = 0; credit_dequeue = 0;
    sample();
    checks++;
    if (sink_valid !== 1'b1 || sink_vc !== 1'b1 || sink_flit !== fb ||
        credit_out_valid !== 1'b1 || credit_out !== 2'b10) begin
      errors++;
      $display("FAIL freeze_resume sv=%b vc=%b flit=%h cv=%b credit=%b required 1 1 %h 1 10",
               sink_valid, sink_vc, sink_flit, credit_out_valid, credit_out, fb);
    end
    advance();
    reset = 1; flit_in_valid = 1; sink_ready = 1;
    sample(); advance();
    reset = 0; flit_in_valid = 0; sink_ready = 0;
    sample();
    checks++;
    if (is_quiescent !== 1'b1) begin errors++; $display("FAIL midreset_quiet got %b required 1", is_quiescent); end
    advance();
    idle_inputs();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset          = ($urandom_range(63) == 0);
      enable         = ($urandom_range(9) != 0);
      flit_in_valid  = ($urandom_range(9) < 6);
      flit_in        = {4'($urandom), 32'($urandom)};
      nexthop_in     = ($urandom_range(49) == 0) ? AW'(MY + 2) : AW'(MY);
      sink_ready     = ($urandom_range(9) < 6);
      credit_dequeue = ($urandom_range(1) == 1);
      sample();
      checks += 8;
      if (dequeue !== e_deq) begin errors++; $display("FAIL rand_deq c%0d got %b required %b", c, dequeue, e_deq); end
      if (sink_valid !== e_sv) begin errors++; $display("FAIL rand_sv c%0d got %b required %b", c, sink_valid, e_sv); end
      if (sink_vc !== e_svc) begin errors++; $display("FAIL rand_svc c%0d got %b required %b", c, sink_vc, e_svc); end
      if (sink_flit !== e_flit) begin errors++; $display("FAIL rand_flit c%0d got %h required %h", c, sink_flit, e_flit); end
      if (credit_out_valid !== e_cv) begin errors++; $display("FAIL rand_cv c%0d got %b required %b", c, credit_out_valid, e_cv); end
      if (credit_out !== e_credit) begin errors++; $display("FAIL rand_credit c%0d got %b required %b", c, credit_out, e_credit); end
      if (is_quiescent !== e_quiet) begin errors++; $display("FAIL rand_quiet c%0d got %b required %b", c, is_quiescent, e_quiet); end
      if (error !== e_err) begin errors++; $display("FAIL rand_err c%0d got %b required %b", c, error, e_err); end
      advance();
    end
    reset = 0;
    drain();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    test_reset();
    test_single_flit();
    test_fifo_full();
    test_alternate();
    test_bad_addr();
    test_enable_freeze();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
